// File: rtl/inorder_issue_queue.sv
// In-order issue queue: circular FIFO between decode and register-read.
// It owns the busy-bit scoreboard (set on issue, cleared on writeback).
package exut;
    typedef enum logic [1:0] {
        ALU = 2'd0,
        MUL = 2'd1,
        DIV = 2'd2,
        MEM = 2'd3
    } exe_unit_type_t;

    typedef struct packed {
        exe_unit_type_t exu_type;
        logic           has_rs1;
        logic [4:0]     rs1;
        logic           has_rs2;
        logic [4:0]     rs2;
        logic           has_rd;
        logic [4:0]     rd;
        logic [7:0]     op;
        logic [31:0]    imm;
    } queue_item_t;
endpackage

module inorder_issue_queue
    import exut::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  queue_item_t      enq_item,
    output logic             iss_valid,
    input  logic             iss_ready,
    output queue_item_t      iss_item,
    input  logic [3:0]       exu_ready,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    output logic [PTR_W:0]   count
);

    queue_item_t       mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [31:0]       busy_q, busy_d;
    logic              enq_fire, iss_fire;
    logic              rs1_ok, rs2_ok, rd_ok;

    // A register is usable if not tracked, x0, idle, or written back this very cycle.
    function automatic logic reg_ok(input logic [4:0] r, input logic has,
                                    input logic [31:0] busy,
                                    input logic wbv, input logic [4:0] wbr);
        return !has || (r == 5'd0) || !busy[r] || (wbv && (wbr == r));
    endfunction

    always_comb begin
        iss_item  = mem_q[head_q];
        rs1_ok    = reg_ok(iss_item.rs1, iss_item.has_rs1, busy_q, wb_valid, wb_rd);
        rs2_ok    = reg_ok(iss_item.rs2, iss_item.has_rs2, busy_q, wb_valid, wb_rd);
        rd_ok     = reg_ok(iss_item.rd,  iss_item.has_rd,  busy_q, wb_valid, wb_rd);
        enq_ready = (count_q != (PTR_W+1)'(DEPTH)) && !flush;
        iss_valid = (count_q != '0) && !flush && rs1_ok && rs2_ok && rd_ok
                    && exu_ready[iss_item.exu_type];
        enq_fire  = enq_valid && enq_ready;
        iss_fire  = iss_valid && iss_ready;
        count     = count_q;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + (PTR_W+1)'(enq_fire) - (PTR_W+1)'(iss_fire);
        busy_d  = busy_q;
        if (iss_fire) head_d = head_q + PTR_W'(1);
        if (enq_fire) tail_d = tail_q + PTR_W'(1);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
        // Clear first so a same-cycle issue to the same register re-marks it busy.
        if (wb_valid) busy_d[wb_rd] = 1'b0;
        if (iss_fire && iss_item.has_rd) busy_d[iss_item.rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) mem_q[tail_q] <= enq_item;
    end

endmodule
